// File: rtl/pmem_arbiter_if.sv
// Bundle of signals between the two caches, the arbiter and physical memory.
// The arbiter uses the slave modport; the caches and memory use the master modport.
interface pmem_arbiter_if;
  logic         i_pmem_read;
  logic [31:0]  i_pmem_address;
  logic         i_pmem_resp;
  logic [255:0] i_pmem_rdata;

  logic         d_pmem_read;
  logic         d_pmem_write;
  logic [31:0]  d_pmem_address;
  logic [255:0] d_pmem_wdata;
  logic         d_pmem_resp;
  logic [255:0] d_pmem_rdata;

  logic         pmem_read;
  logic         pmem_write;
  logic [31:0]  pmem_address;
  logic [255:0] pmem_wdata;
  logic         pmem_resp;
  logic [255:0] pmem_rdata;

  modport slave (
    input  i_pmem_read, i_pmem_address,
    output i_pmem_resp, i_pmem_rdata,
    input  d_pmem_read, d_pmem_write, d_pmem_address, d_pmem_wdata,
    output d_pmem_resp, d_pmem_rdata,
    output pmem_read, pmem_write, pmem_address, pmem_wdata,
    input  pmem_resp, pmem_rdata
  );

  modport master (
    output i_pmem_read, i_pmem_address,
    input  i_pmem_resp, i_pmem_rdata,
    output d_pmem_read, d_pmem_write, d_pmem_address, d_pmem_wdata,
    input  d_pmem_resp, d_pmem_rdata,
    input  pmem_read, pmem_write, pmem_address, pmem_wdata,
    output pmem_resp, pmem_rdata
  );
endinterface

// File: rtl/pmem_arbiter.sv
// Round-robin arbiter sharing one physical-memory port between the I-cache and D-cache.
// The winner's request is latched at grant; responses are gated back to the winner only.
module pmem_arbiter (
  input  logic           clk,
  input  logic           rst_n,
  pmem_arbiter_if.slave  bus
);
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] I_BUSY = 2'd1;
  localparam logic [1:0] D_BUSY = 2'd2;

  logic [1:0]   state_reg;
  logic         last_d_reg;
  logic         pmem_read_reg;
  logic         pmem_write_reg;
  logic [31:0]  pmem_address_reg;
  logic [255:0] pmem_wdata_reg;

  logic i_req;
  logic d_req;
  logic grant_i;
  logic grant_d;

  // Arbitration only looks at requests while IDLE; busy states ignore the inputs entirely.
  always_comb begin
    i_req   = bus.i_pmem_read;
    d_req   = bus.d_pmem_read | bus.d_pmem_write;
    grant_i = (state_reg == IDLE) && i_req && (!d_req || last_d_reg);
    grant_d = (state_reg == IDLE) && d_req && !grant_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg        <= IDLE;
      last_d_reg       <= 1'b1;
      pmem_read_reg    <= 1'b0;
      pmem_write_reg   <= 1'b0;
      pmem_address_reg <= '0;
      pmem_wdata_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (grant_i) begin
            pmem_address_reg <= bus.i_pmem_address;
            pmem_read_reg    <= 1'b1;
            pmem_write_reg   <= 1'b0;
            last_d_reg       <= 1'b0;
            state_reg        <= I_BUSY;
          end else if (grant_d) begin
            // A simultaneous read+write from the D-cache is served as a writeback.
            pmem_address_reg <= bus.d_pmem_address;
            pmem_wdata_reg   <= bus.d_pmem_wdata;
            pmem_read_reg    <= ~bus.d_pmem_write;
            pmem_write_reg   <= bus.d_pmem_write;
            last_d_reg       <= 1'b1;
            state_reg        <= D_BUSY;
          end
        end
        I_BUSY, D_BUSY: begin
          if (bus.pmem_resp) begin
            pmem_read_reg  <= 1'b0;
            pmem_write_reg <= 1'b0;
            state_reg      <= IDLE;
          end
        end
        default: begin
          pmem_read_reg  <= 1'b0;
          pmem_write_reg <= 1'b0;
          state_reg      <= IDLE;
        end
      endcase
    end
  end

  assign bus.pmem_read    = pmem_read_reg;
  assign bus.pmem_write   = pmem_write_reg;
  assign bus.pmem_address = pmem_address_reg;
  assign bus.pmem_wdata   = pmem_wdata_reg;

  assign bus.i_pmem_resp  = bus.pmem_resp & (state_reg == I_BUSY);
  assign bus.d_pmem_resp  = bus.pmem_resp & (state_reg == D_BUSY);
  assign bus.i_pmem_rdata = bus.pmem_rdata;
  assign bus.d_pmem_rdata = bus.pmem_rdata;
endmodule

// File: tb/tb_pmem_arbiter.sv
// Bench for pmem_arbiter: directed scenarios plus randomized cache traffic checked
// against a transaction-level model of round-robin arbitration and a line memory.
module tb_pmem_arbiter;
  logic clk;
  logic rst_n;
  pmem_arbiter_if bus();

  pmem_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Physical-memory model state
  int  mem_lat  = 1;
  bit  mem_rand = 0;
  bit  stray_req = 0;
  int  wait_cnt = 0;
  int  cur_lat  = 1;
  logic [255:0] phys_mem [logic [31:0]];
  logic [255:0] ref_mem  [logic [31:0]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [255:0] line_for(input logic [31:0] a);
    logic [255:0] l;
    for (int w = 0; w < 8; w++) l[w*32 +: 32] = a ^ (32'h1357_9BDF * (w + 1));
    return l;
  endfunction

  function automatic logic [255:0] rand_line();
    logic [255:0] l;
    for (int w = 0; w < 8; w++) l[w*32 +: 32] = $urandom;
    return l;
  endfunction

  function automatic logic [255:0] ref_read(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : line_for(a);
  endfunction

  // Physical memory: answers each access after its latency with a one-cycle resp.
  initial begin
    bus.pmem_resp  = 1'b0;
    bus.pmem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      if (bus.pmem_resp) begin
        bus.pmem_resp = 1'b0;
        wait_cnt = 0;
      end else if (stray_req) begin
        bus.pmem_resp  = 1'b1;
        bus.pmem_rdata = rand_line();
        stray_req = 0;
      end else if (rst_n && (bus.pmem_read || bus.pmem_write)) begin
        if (wait_cnt == 0) cur_lat = mem_rand ? int'($urandom_range(1, 4)) : mem_lat;
        wait_cnt++;
        if (wait_cnt >= cur_lat) begin
          bus.pmem_resp = 1'b1;
          if (bus.pmem_write) phys_mem[bus.pmem_address] = bus.pmem_wdata;
          else bus.pmem_rdata = phys_mem.exists(bus.pmem_address) ?
                                phys_mem[bus.pmem_address] : line_for(bus.pmem_address);
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  task automatic clear_inputs();
    bus.i_pmem_read    = 1'b0;
    bus.i_pmem_address = '0;
    bus.d_pmem_read    = 1'b0;
    bus.d_pmem_write   = 1'b0;
    bus.d_pmem_address = '0;
    bus.d_pmem_wdata   = '0;
  endtask

  // Leaves the bench at posedge+1 of the first cycle after reset release.
  task automatic apply_reset();
    rst_n = 1'b0;
    clear_inputs();
    mem_rand = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({bus.pmem_read, bus.pmem_write} !== 2'b00) begin
      n_err++; $display("FAIL reset_rw: got %b required 00", {bus.pmem_read, bus.pmem_write});
    end
    n_cmp++;
    if (bus.pmem_address !== 32'h0 || bus.pmem_wdata !== 256'h0) begin
      n_err++; $display("FAIL reset_latch: got addr %h wdata %h required 0", bus.pmem_address, bus.pmem_wdata);
    end
    n_cmp++;
    if ({bus.i_pmem_resp, bus.d_pmem_resp} !== 2'b00) begin
      n_err++; $display("FAIL reset_resp: got %b required 00", {bus.i_pmem_resp, bus.d_pmem_resp});
    end
    $display("test_reset: outputs idle under reset");
  endtask

  task automatic test_lone_i();
    int  lat = 3;
    int  resps = 0;
    bit  drop = 0;
    apply_reset();
    mem_lat = lat;
    bus.i_pmem_read = 1'b1;
    bus.i_pmem_address = 32'h0000_0060;
    @(negedge clk);
    n_cmp++;
    if (bus.pmem_read !== 1'b0) begin
      n_err++; $display("FAIL lone_i_comb: pmem_read %b in request cycle, required 0", bus.pmem_read);
    end
    for (int cyc = 1; cyc <= 8; cyc++) begin
      @(posedge clk); #1;
      if (drop) bus.i_pmem_read = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (bus.pmem_read !== (cyc <= lat) || bus.pmem_write !== 1'b0 ||
          (cyc <= lat && bus.pmem_address !== 32'h60)) begin
        n_err++; $display("FAIL lone_i_cyc%0d: got rd %b wr %b addr %h required rd %b addr 60",
                          cyc, bus.pmem_read, bus.pmem_write, bus.pmem_address, cyc <= lat);
      end
      n_cmp++;
      if (bus.i_pmem_resp !== (cyc == lat) || bus.d_pmem_resp !== 1'b0) begin
        n_err++; $display("FAIL lone_i_resp%0d: got i %b d %b required i %b d 0",
                          cyc, bus.i_pmem_resp, bus.d_pmem_resp, cyc == lat);
      end
      if (bus.i_pmem_resp) begin
        resps++;
        drop = 1;
        n_cmp++;
        if (bus.i_pmem_rdata !== line_for(32'h60)) begin
          n_err++; $display("FAIL lone_i_data: got %h required %h", bus.i_pmem_rdata, line_for(32'h60));
        end
      end
    end
    n_cmp++;
    if (resps != 1) begin
      n_err++; $display("FAIL lone_i_count: got %0d responses required 1", resps);
    end
    $display("test_lone_i: I read 0x60 latency %0d, %0d response(s)", lat, resps);
  endtask

  task automatic test_conflict();
    int lat = 2;
    int i_end, d_start, d_end;
    bit drop_i = 0, drop_d = 0;
    logic [255:0] wd;
    wd = {8{32'hDEAD_BEEF}};
    i_end = lat; d_start = i_end + 2; d_end = d_start + lat - 1;
    apply_reset();
    mem_lat = lat;
    bus.i_pmem_read = 1'b1;    bus.i_pmem_address = 32'h80;
    bus.d_pmem_write = 1'b1;   bus.d_pmem_address = 32'h1000;
    bus.d_pmem_wdata = wd;
    for (int cyc = 1; cyc <= d_end + 2; cyc++) begin
      @(posedge clk); #1;
      if (drop_i) bus.i_pmem_read = 1'b0;
      if (drop_d) bus.d_pmem_write = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (bus.pmem_read !== (cyc >= 1 && cyc <= i_end) ||
          bus.pmem_write !== (cyc >= d_start && cyc <= d_end)) begin
        n_err++; $display("FAIL conflict_cyc%0d: got rd %b wr %b required rd %b wr %b", cyc,
                          bus.pmem_read, bus.pmem_write, cyc <= i_end, cyc >= d_start && cyc <= d_end);
      end
      if (cyc >= d_start && cyc <= d_end) begin
        n_cmp++;
        if (bus.pmem_address !== 32'h1000 || bus.pmem_wdata !== wd) begin
          n_err++; $display("FAIL conflict_dlatch: got addr %h wdata %h required 1000 / %h",
                            bus.pmem_address, bus.pmem_wdata, wd);
        end
      end
      n_cmp++;
      if (bus.i_pmem_resp !== (cyc == i_end) || bus.d_pmem_resp !== (cyc == d_end)) begin
        n_err++; $display("FAIL conflict_resp%0d: got i %b d %b required i %b d %b", cyc,
                          bus.i_pmem_resp, bus.d_pmem_resp, cyc == i_end, cyc == d_end);
      end
      if (bus.i_pmem_resp) drop_i = 1;
      if (bus.d_pmem_resp) drop_d = 1;
    end
    clear_inputs();
    $display("test_conflict: I first then D write at cycle %0d", d_start);
  endtask

  task automatic test_alternate();
    int lat = 2;
    int grants = 0, resps = 0;
    bit act, act_prev = 0, owner_d = 0;
    apply_reset();
    mem_lat = lat;
    bus.i_pmem_read = 1'b1; bus.i_pmem_address = 32'h100;
    bus.d_pmem_read = 1'b1; bus.d_pmem_address = 32'h200;
    for (int cyc = 0; cyc < 40 && resps < 6; cyc++) begin
      @(negedge clk);
      act = bus.pmem_read || bus.pmem_write;
      if (act && !act_prev) begin
        owner_d = (grants % 2) == 1;
        n_cmp++;
        if (cyc != 1 + grants * (lat + 1) ||
            bus.pmem_address !== (owner_d ? 32'h200 : 32'h100)) begin
          n_err++; $display("FAIL alternate_grant%0d: got cycle %0d addr %h required cycle %0d addr %h",
                            grants, cyc, bus.pmem_address, 1 + grants * (lat + 1),
                            owner_d ? 32'h200 : 32'h100);
        end
        grants++;
      end
      if (bus.pmem_resp && act) begin
        n_cmp++;
        if (bus.i_pmem_resp !== !owner_d || bus.d_pmem_resp !== owner_d) begin
          n_err++; $display("FAIL alternate_route%0d: got i %b d %b required i %b d %b", resps,
                            bus.i_pmem_resp, bus.d_pmem_resp, !owner_d, owner_d);
        end
        resps++;
      end
      act_prev = act;
      @(posedge clk); #1;
    end
    clear_inputs();
    n_cmp++;
    if (resps != 6) begin
      n_err++; $display("FAIL alternate_count: got %0d transactions required 6", resps);
    end
    $display("test_alternate: %0d grants, %0d completions", grants, resps);
  endtask

  task automatic test_addr_change();
    int lat = 4;
    int resps = 0;
    bit drop = 0;
    apply_reset();
    mem_lat = lat;
    bus.d_pmem_write = 1'b1; bus.d_pmem_address = 32'h2000;
    bus.d_pmem_wdata = rand_line();
    for (int cyc = 1; cyc <= lat + 2; cyc++) begin
      @(posedge clk); #1;
      if (cyc == 2) bus.d_pmem_address = 32'h3000;
      if (drop) bus.d_pmem_write = 1'b0;
      @(negedge clk);
      if (cyc <= lat) begin
        n_cmp++;
        if (bus.pmem_address !== 32'h2000 || bus.pmem_write !== 1'b1) begin
          n_err++; $display("FAIL addr_hold%0d: got addr %h wr %b required 2000 / 1",
                            cyc, bus.pmem_address, bus.pmem_write);
        end
      end
      n_cmp++;
      if (bus.d_pmem_resp !== (cyc == lat)) begin
        n_err++; $display("FAIL addr_resp%0d: got %b required %b", cyc, bus.d_pmem_resp, cyc == lat);
      end
      if (bus.d_pmem_resp) begin resps++; drop = 1; end
    end
    clear_inputs();
    $display("test_addr_change: address held at 0x2000, %0d response(s)", resps);
  endtask

  task automatic test_stray();
    apply_reset();
    mem_lat = 1;
    @(negedge clk);
    stray_req = 1;
    @(negedge clk);
    n_cmp++;
    if ({bus.i_pmem_resp, bus.d_pmem_resp, bus.pmem_read, bus.pmem_write} !== 4'b0000) begin
      n_err++; $display("FAIL stray_idle: got i %b d %b rd %b wr %b required all 0",
                        bus.i_pmem_resp, bus.d_pmem_resp, bus.pmem_read, bus.pmem_write);
    end
    @(posedge clk); #1;
    bus.d_pmem_read = 1'b1; bus.d_pmem_address = 32'h500;
    @(negedge clk);
    n_cmp++;
    if (bus.pmem_read !== 1'b0) begin
      n_err++; $display("FAIL stray_req_cycle: got rd %b required 0", bus.pmem_read);
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++;
    if (bus.pmem_read !== 1'b1 || bus.pmem_address !== 32'h500 ||
        bus.d_pmem_resp !== 1'b1 || bus.i_pmem_resp !== 1'b0) begin
      n_err++; $display("FAIL stray_then_grant: got rd %b addr %h d %b i %b required 1 / 500 / 1 / 0",
                        bus.pmem_read, bus.pmem_address, bus.d_pmem_resp, bus.i_pmem_resp);
    end
    n_cmp++;
    if (bus.d_pmem_rdata !== line_for(32'h500)) begin
      n_err++; $display("FAIL stray_data: got %h required %h", bus.d_pmem_rdata, line_for(32'h500));
    end
    @(posedge clk); #1;
    clear_inputs();
    $display("test_stray: stray resp ignored, D read granted afterwards");
  endtask

  task automatic test_reset_mid();
    apply_reset();
    mem_lat = 10;
    bus.d_pmem_write = 1'b1; bus.d_pmem_address = 32'h4000;
    bus.d_pmem_wdata = rand_line();
    @(posedge clk); #1;
    bus.i_pmem_read = 1'b1; bus.i_pmem_address = 32'h700;
    @(negedge clk);
    n_cmp++;
    if (bus.pmem_write !== 1'b1 || bus.pmem_address !== 32'h4000) begin
      n_err++; $display("FAIL rstmid_busy: got wr %b addr %h required 1 / 4000",
                        bus.pmem_write, bus.pmem_address);
    end
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus.pmem_read, bus.pmem_write} !== 2'b00 || bus.pmem_address !== 32'h0 ||
        bus.pmem_wdata !== 256'h0) begin
      n_err++; $display("FAIL rstmid_async: got rd %b wr %b addr %h required 0 0 0",
                        bus.pmem_read, bus.pmem_write, bus.pmem_address);
    end
    mem_lat = 1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({bus.i_pmem_resp, bus.d_pmem_resp, bus.pmem_read, bus.pmem_write} !== 4'b0000) begin
      n_err++; $display("FAIL rstmid_idle: got i %b d %b rd %b wr %b required all 0",
                        bus.i_pmem_resp, bus.d_pmem_resp, bus.pmem_read, bus.pmem_write);
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++;
    if (bus.pmem_read !== 1'b1 || bus.pmem_write !== 1'b0 || bus.pmem_address !== 32'h700 ||
        bus.i_pmem_resp !== 1'b1 || bus.d_pmem_resp !== 1'b0) begin
      n_err++; $display("FAIL rstmid_i_first: got rd %b wr %b addr %h i %b d %b required 1 0 700 1 0",
                        bus.pmem_read, bus.pmem_write, bus.pmem_address, bus.i_pmem_resp, bus.d_pmem_resp);
    end
    @(posedge clk); #1;
    clear_inputs();
    $display("test_reset_mid: write abandoned, I granted first after reset");
  endtask

  // Randomized traffic: each cache issues requests, holds them until resp, then
  // idles a random gap. The model picks the expected winner of every grant.
  task automatic test_random();
    bit ip = 0, dp = 0, dw = 0, dboth = 0;
    logic [31:0] ia = '0, da = '0;
    logic [255:0] dd = '0;
    bit s_ip, s_dp, s_dw, p_ip = 0, p_dp = 0, p_dw = 0;
    logic [31:0] s_ia, s_da, p_ia = '0, p_da = '0, lat_addr = '0;
    logic [255:0] s_dd, p_dd = '0;
    int igap, dgap, done = 0, target = 150;
    bit act, act_prev = 0, cur_d = 0, m_last_d = 1, exp_i, exp_d, win_d;
    apply_reset();
    mem_rand = 1;
    igap = $urandom_range(0, 2);
    dgap = $urandom_range(0, 2);
    for (int cyc = 0; cyc < 5000 && done < target; cyc++) begin
      if (!ip) begin
        if (igap == 0) begin ip = 1; ia = {23'd0, 4'($urandom_range(0, 15)), 5'd0}; end
        else igap--;
      end
      if (!dp) begin
        if (dgap == 0) begin
          dp = 1;
          dw = $urandom_range(0, 1) == 1;
          dboth = dw && ($urandom_range(0, 7) == 0);
          da = {23'd0, 4'($urandom_range(0, 15)), 5'd0};
          dd = rand_line();
        end else dgap--;
      end
      bus.i_pmem_read    = ip;
      bus.i_pmem_address = ip ? ia : $urandom;
      bus.d_pmem_read    = dp && (!dw || dboth);
      bus.d_pmem_write   = dp && dw;
      bus.d_pmem_address = dp ? da : $urandom;
      bus.d_pmem_wdata   = dp ? dd : rand_line();
      s_ip = ip; s_ia = ia; s_dp = dp; s_dw = dw; s_da = da; s_dd = dd;
      @(negedge clk);
      act = bus.pmem_read || bus.pmem_write;
      if (act && !act_prev) begin
        win_d = p_dp && (!p_ip || !m_last_d);
        n_cmp++;
        if (!(p_ip || p_dp)) begin
          n_err++; $display("FAIL rand_spurious_grant: cycle %0d grant with no request", cyc);
        end else if (win_d) begin
          if (bus.pmem_address !== p_da || bus.pmem_write !== p_dw || bus.pmem_read !== !p_dw ||
              (p_dw && bus.pmem_wdata !== p_dd)) begin
            n_err++; $display("FAIL rand_grant_d: cycle %0d got rd %b wr %b addr %h required rd %b wr %b addr %h",
                              cyc, bus.pmem_read, bus.pmem_write, bus.pmem_address, !p_dw, p_dw, p_da);
          end
        end else begin
          if (bus.pmem_address !== p_ia || bus.pmem_read !== 1'b1 || bus.pmem_write !== 1'b0) begin
            n_err++; $display("FAIL rand_grant_i: cycle %0d got rd %b wr %b addr %h required rd 1 wr 0 addr %h",
                              cyc, bus.pmem_read, bus.pmem_write, bus.pmem_address, p_ia);
          end
        end
        cur_d = win_d;
        m_last_d = win_d;
        lat_addr = win_d ? p_da : p_ia;
      end else if (act) begin
        n_cmp++;
        if (bus.pmem_address !== lat_addr) begin
          n_err++; $display("FAIL rand_hold: cycle %0d got addr %h required %h", cyc, bus.pmem_address, lat_addr);
        end
      end else if (!act_prev && (p_ip || p_dp)) begin
        n_cmp++; n_err++;
        $display("FAIL rand_missed_grant: cycle %0d no grant, pending i %b d %b", cyc, p_ip, p_dp);
      end
      exp_i = bus.pmem_resp && act && !cur_d;
      exp_d = bus.pmem_resp && act && cur_d;
      n_cmp++;
      if (bus.i_pmem_resp !== exp_i || bus.d_pmem_resp !== exp_d) begin
        n_err++; $display("FAIL rand_route: cycle %0d got i %b d %b required i %b d %b",
                          cyc, bus.i_pmem_resp, bus.d_pmem_resp, exp_i, exp_d);
      end
      if (exp_i) begin
        n_cmp++;
        if (bus.i_pmem_rdata !== ref_read(ia)) begin
          n_err++; $display("FAIL rand_i_data: addr %h got %h required %h", ia, bus.i_pmem_rdata, ref_read(ia));
        end
        ip = 0; igap = $urandom_range(0, 3); done++;
      end
      if (exp_d) begin
        if (dw) ref_mem[da] = dd;
        else begin
          n_cmp++;
          if (bus.d_pmem_rdata !== ref_read(da)) begin
            n_err++; $display("FAIL rand_d_data: addr %h got %h required %h", da, bus.d_pmem_rdata, ref_read(da));
          end
        end
        dp = 0; dgap = $urandom_range(0, 3); done++;
      end
      act_prev = act;
      p_ip = s_ip; p_ia = s_ia; p_dp = s_dp; p_dw = s_dw; p_da = s_da; p_dd = s_dd;
      @(posedge clk); #1;
    end
    clear_inputs();
    n_cmp++;
    if (done < target) begin
      n_err++; $display("FAIL rand_timeout: got %0d completions required %0d", done, target);
    end
    $display("test_random: %0d transactions completed", done);
  endtask

  initial begin
    rst_n = 1'b0;
    clear_inputs();
    test_reset();
    test_lone_i();
    test_conflict();
    test_alternate();
    test_addr_change();
    test_stray();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/pmem_arbiter.md
# pmem_arbiter

Arbiter sharing one physical-memory port between the instruction cache and the data cache in the split-cache RV32I pipeline. It accepts cacheline read requests from the I-cache and cacheline read/write requests from the D-cache, grants one at a time with round-robin fairness, latches the winner's address and data, and runs the physical-memory handshake. It routes the response back to the winner only. It sits between the two `cache` instances and physical memory, and is transparent to each cache's control FSM.

## Interface
- Parameters: none. Widths are fixed by `rv32i_types`: `rv32i_word` is 32 bits and `rv32i_cacheline` is 256 bits.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `i_pmem_read` in 1: I-cache line-read request; held high until `i_pmem_resp`.
- `i_pmem_address` in 32: I-cache line address.
- `i_pmem_resp` out 1: I-cache completion pulse.
- `i_pmem_rdata` out 256: line data to the I-cache.
- `d_pmem_read` in 1: D-cache line-read request; held until `d_pmem_resp`.
- `d_pmem_write` in 1: D-cache writeback request; held until `d_pmem_resp`.
- `d_pmem_address` in 32: D-cache line address.
- `d_pmem_wdata` in 256: D-cache writeback line.
- `d_pmem_resp` out 1: D-cache completion pulse.
- `d_pmem_rdata` out 256: line data to the D-cache.
- `pmem_read` out 1: read to physical memory; registered.
- `pmem_write` out 1: write to physical memory; registered.
- `pmem_address` out 32: registered latched address.
- `pmem_wdata` out 256: registered latched write line.
- `pmem_resp` in 1: physical-memory completion pulse; one cycle.
- `pmem_rdata` in 256: physical-memory line data, valid with `pmem_resp`.

## Operation
- FSM states:
  - IDLE: no transaction in flight.
  - I_BUSY: serving the I-cache.
  - D_BUSY: serving the D-cache.
- `last_d` flag records the last requester served: 1 means D was served last. Reset value is 1, so I wins the first conflict.
- Behaviour in IDLE:
  - `i_req = i_pmem_read`; `d_req = d_pmem_read | d_pmem_write`.
  - Only one requester pending: grant it.
  - Both pending: grant I if `last_d = 1`, otherwise grant D.
  - On grant:
    - latch the winner's address into `pmem_address`;
    - latch `d_pmem_wdata` into `pmem_wdata` (D grant only);
    - set `pmem_read`/`pmem_write`;
    - update `last_d`;
    - move to the matching BUSY state.
- D request with both `d_pmem_read` and `d_pmem_write` high (illegal): treated as a write.
- Behaviour in a BUSY state:
  - Latched outputs stay constant.
  - Request inputs are ignored, including a withdrawn request or changed address; the transaction always completes.
  - On `pmem_resp`: clear `pmem_read`/`pmem_write` and go to IDLE.
- Response routing is combinational:
  - `i_pmem_resp = pmem_resp & (state == I_BUSY)`.
  - `d_pmem_resp = pmem_resp & (state == D_BUSY)`.
  - `i_pmem_rdata = d_pmem_rdata = pmem_rdata` (broadcast); harmless because resp is gated.
- `pmem_resp` in IDLE is ignored: no resp forwarded, no state change.
- Reset values: state IDLE; `pmem_read`, `pmem_write` = 0; `pmem_address` = 0; `pmem_wdata` = 0; `last_d` = 1.
- Reset asserted mid-transaction: outputs drop immediately (asynchronous) and the in-flight access is abandoned. No resp is forwarded after reset. The physical-memory model must tolerate a dropped request.

## Timing
- Cycle 0: request seen in IDLE. Edge 0→1: grant is registered.
- Cycle 1: `pmem_read` or `pmem_write` high with latched address.
- Memory latency N: `pmem_resp` in cycle 1+N−1 at the earliest; `pmem_resp` in cycle 1 is legal for N=1.
- The cache sees resp in the same cycle as `pmem_resp`, with zero added return latency.
- Arbitration overhead: 1 cycle per transaction; IDLE always lasts at least 1 cycle.
- Back-to-back: a request held or newly raised in the cycle after resp is granted at the next edge. Example: D writeback followed by D fill.
- Losing requester waits for the full winner transaction plus 1 IDLE cycle.
- Worst case: two lines of latency plus 2 cycles.
- No combinational path from request inputs to `pmem_*` outputs.

## Test plan
- Lone I read of `0x0000_0060`, memory latency 3:
  - `pmem_read` high from cycle 1 with address `0x60`;
  - `i_pmem_resp` pulses one cycle with the line;
  - `d_pmem_resp` stays 0.
- I read and D write (address `0x1000`, wdata `{8{32'hDEADBEEF}}`) raised in the same cycle after reset:
  - I is served first, then D, after exactly one IDLE cycle;
  - `pmem_wdata` matches.
- Both requesters held continuously for 6 transactions:
  - grants alternate I,D,I,D,I,D;
  - neither requester starves.
- D changes `d_pmem_address` from `0x2000` to `0x3000` mid-transaction:
  - `pmem_address` stays `0x2000` until resp.
- Stray `pmem_resp` while IDLE:
  - no resp forwarded to either cache;
  - state unchanged.
- `rst_n` low during D_BUSY:
  - `pmem_write` drops without waiting for an edge;
  - after release, state is IDLE and `last_d` = 1;
  - a pending I read is granted first.
